// File: rtl/rtc_time_cnt.sv
`default_nettype none
// ============================================================================
// Module   : rtc_time_cnt
// Brief    : Settable time-of-day counter (hour/minute/second) with a
//            programmable one-second prescaler, run/pause, range-checked
//            full-time load, per-field manual adjust, and carry pulses.
//            Optional alarm compare enabled by macro TIME_CNT_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_time_cnt #(
    parameter int CNT_1S_MAX = 49_999_999,
    parameter int CNT_W      = 26,
    parameter int HOUR_MAX   = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [5:0] load_hour,
    input  logic [5:0] load_minute,
    input  logic [5:0] load_second,
    input  logic [1:0] adj_sel,
    input  logic       adj_inc,
`ifdef TIME_CNT_ALARM_EN
    input  logic       alarm_set,
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    output logic       alarm_hit,
`endif
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       tick_1s,
    output logic       day_wrap,
    output logic       load_err
);

    localparam logic [CNT_W-1:0] c_PRESC_MAX = CNT_W'(CNT_1S_MAX);
    localparam logic [5:0]       c_HOUR_MAX  = 6'(HOUR_MAX);
    localparam logic [5:0]       c_MS_MAX    = 6'd59;

    logic [CNT_W-1:0] r_presc;
    logic [5:0]       r_hour;
    logic [5:0]       r_minute;
    logic [5:0]       r_second;
    logic             r_tick;
    logic             r_wrap;
    logic             r_err;

    logic [CNT_W-1:0] w_presc_nxt;
    logic [5:0]       w_hour_nxt;
    logic [5:0]       w_minute_nxt;
    logic [5:0]       w_second_nxt;
    logic             w_tick_nxt;
    logic             w_wrap_nxt;
    logic             w_err_nxt;

    logic             w_load_ok;
    logic             w_adj;

    assign w_load_ok = (load_hour <= c_HOUR_MAX) && (load_minute <= c_MS_MAX)
                    && (load_second <= c_MS_MAX);
    // A select of 0 means no field, so the pulse is not an event at all
    assign w_adj     = adj_inc && (adj_sel != 2'd0);

    // Next-state: load beats adjust beats the natural count
    always_comb begin
        w_presc_nxt  = r_presc;
        w_hour_nxt   = r_hour;
        w_minute_nxt = r_minute;
        w_second_nxt = r_second;
        w_tick_nxt   = 1'b0;
        w_wrap_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        if (load) begin
            // A rejected load freezes everything, including the prescaler
            if (w_load_ok) begin
                w_hour_nxt   = load_hour;
                w_minute_nxt = load_minute;
                w_second_nxt = load_second;
                w_presc_nxt  = '0;
            end else begin
                w_err_nxt    = 1'b1;
            end
        end else if (w_adj) begin
            // Prescaler is left untouched so a terminal count slips by one cycle
            case (adj_sel)
                2'd1:    w_second_nxt = (r_second == c_MS_MAX)   ? 6'd0 : r_second + 6'd1;
                2'd2:    w_minute_nxt = (r_minute == c_MS_MAX)   ? 6'd0 : r_minute + 6'd1;
                2'd3:    w_hour_nxt   = (r_hour   == c_HOUR_MAX) ? 6'd0 : r_hour   + 6'd1;
                default: ;
            endcase
        end else if (en) begin
            if (r_presc == c_PRESC_MAX) begin
                w_presc_nxt = '0;
                w_tick_nxt  = 1'b1;
                if (r_second == c_MS_MAX) begin
                    w_second_nxt = 6'd0;
                    if (r_minute == c_MS_MAX) begin
                        w_minute_nxt = 6'd0;
                        if (r_hour == c_HOUR_MAX) begin
                            w_hour_nxt = 6'd0;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_hour_nxt = r_hour + 6'd1;
                        end
                    end else begin
                        w_minute_nxt = r_minute + 6'd1;
                    end
                end else begin
                    w_second_nxt = r_second + 6'd1;
                end
            end else begin
                w_presc_nxt = r_presc + 1'b1;
            end
        end
    end

    // Time, prescaler and event pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc  <= '0;
            r_hour   <= 6'd0;
            r_minute <= 6'd0;
            r_second <= 6'd0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_presc  <= w_presc_nxt;
            r_hour   <= w_hour_nxt;
            r_minute <= w_minute_nxt;
            r_second <= w_second_nxt;
            r_tick   <= w_tick_nxt;
            r_wrap   <= w_wrap_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign hour     = r_hour;
    assign minute   = r_minute;
    assign second   = r_second;
    assign tick_1s  = r_tick;
    assign day_wrap = r_wrap;
    assign load_err = r_err;

`ifdef TIME_CNT_ALARM_EN
    logic [5:0] r_alarm_hour;
    logic [5:0] r_alarm_minute;
    logic       r_alarm_arm;
    logic       r_alarm_hit;
    logic       w_alarm_ok;
    logic       w_alarm_hit_nxt;

    assign w_alarm_ok = (alarm_hour <= c_HOUR_MAX) && (alarm_minute <= c_MS_MAX);

    // Only a natural advance carries w_tick_nxt, so load/adjust never match
    assign w_alarm_hit_nxt = r_alarm_arm && w_tick_nxt
                          && (w_hour_nxt   == r_alarm_hour)
                          && (w_minute_nxt == r_alarm_minute)
                          && (w_second_nxt == 6'd0);

    // Alarm time latch, arm flag and hit pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alarm_hour   <= 6'd0;
            r_alarm_minute <= 6'd0;
            r_alarm_arm    <= 1'b0;
            r_alarm_hit    <= 1'b0;
        end else begin
            if (alarm_set && w_alarm_ok) begin
                r_alarm_hour   <= alarm_hour;
                r_alarm_minute <= alarm_minute;
                r_alarm_arm    <= 1'b1;
            end
            r_alarm_hit <= w_alarm_hit_nxt;
        end
    end

    assign alarm_hit = r_alarm_hit;
`endif

endmodule
`default_nettype wire

// File: doc/rtc_time_cnt.md
Name: rtc_time_cnt

Overview:
Settable, parametrised time-of-day counter producing hour/minute/second for the segment-display path. Generalises the fixed 50 MHz free-running counter:
- programmable prescaler, so simulation can use a short second;
- run/pause control;
- full-time load with range checking;
- per-field manual adjust for the key-driven set mode;
- carry/event pulses for downstream blocks.

Parameters:
CNT_1S_MAX, 49_999_999, prescaler terminal count; one second = CNT_1S_MAX+1 clk cycles
CNT_W, 26, prescaler width; must satisfy 2^CNT_W > CNT_1S_MAX
HOUR_MAX, 23, last hour value before wrap (23 = 24 h day)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous assert, active low
en  in  1  1 = time runs; 0 = prescaler and time frozen
load  in  1  single-cycle pulse; load load_hour/load_minute/load_second
load_hour  in  6  value to load into hour
load_minute  in  6  value to load into minute
load_second  in  6  value to load into second
adj_sel  in  2  0 none, 1 second, 2 minute, 3 hour
adj_inc  in  1  single-cycle pulse; +1 to selected field
hour  out  6  0..HOUR_MAX
minute  out  6  0..59
second  out  6  0..59
tick_1s  out  1  pulse on natural second advance
day_wrap  out  1  pulse on HOUR_MAX:59:59 -> 00:00:00 natural rollover
load_err  out  1  pulse; load rejected

Behaviour:
- Reset (rst=0, async): prescaler, hour, minute, second = 0; tick_1s, day_wrap, load_err = 0.
- All outputs are registered. Pulses are exactly one cycle wide and coincide with the cycle the new time value is visible.
- Per-edge priority: load > adj (adj_inc=1 and adj_sel!=0) > natural count. adj_inc with adj_sel=0 is ignored and counts as no event.

Load:
- Valid when load_hour<=HOUR_MAX, load_minute<=59 and load_second<=59.
- Valid load: all three fields take the load values; prescaler cleared to 0; tick_1s and day_wrap forced 0.
- Invalid load: nothing changes (time and prescaler hold); load_err=1 next cycle.
- Load is honoured regardless of en.

Adjust:
- Selected field +1, wrapping to 0 past its max (59, or HOUR_MAX for hour).
- No carry into the next field.
- Prescaler held that cycle, so a coincident natural tick is deferred by exactly one cycle, not lost.
- Honoured regardless of en.

Natural count (en=1, no load/adj):
- Prescaler increments; at CNT_1S_MAX it returns to 0 and second advances.
- second 59 -> 0 carries to minute; minute 59 -> 0 carries to hour; hour HOUR_MAX -> 0 raises day_wrap.
- tick_1s=1 on every natural advance.

en=0: prescaler and time hold. tick_1s and day_wrap stay 0.

Latency:
- After a valid load with en=1 throughout, the first tick_1s occurs CNT_1S_MAX+1 cycles later.
- en deassertion takes effect on the next edge.

Field values outside their range are unreachable, since all entry paths are range-checked.

Reset mid-second discards the partial prescaler count.

Optional Feature:
Macro TIME_CNT_ALARM_EN.

When defined, the following ports are added:
- alarm_set in 1: pulse
- alarm_hour in 6
- alarm_minute in 6
- alarm_hit out 1

Alarm behaviour:
- alarm_set latches the alarm time. A value outside range is ignored.
- Alarm register resets to 0:00 and is disarmed.
- A valid alarm_set arms the alarm.
- alarm_hit pulses one cycle when a natural advance produces alarm_hour:alarm_minute:00.
- Load and adjust never raise alarm_hit.

When undefined, none of these ports or registers exist, and behaviour is otherwise identical.

Test Plan:
1. CNT_1S_MAX=4, reset, en=1 -> second=1 with tick_1s on the 5th edge after reset release; minute=1 after 300 cycles.
2. Load 23:59:58, en=1 -> 23:59:59 after 5 cycles, then 00:00:00 with day_wrap=1 and tick_1s=1 5 cycles later.
3. Load 24:00:00 or 12:60:00 -> load_err=1 for one cycle; time unchanged.
4. Time 10:59:59, adj_sel=2, adj_inc -> 10:00:59 with no hour carry. adj_inc on the prescaler terminal cycle -> tick_1s arrives one cycle late.
5. en=0 for 20 cycles mid-second -> no change; en=1 -> tick resumes after the remaining prescaler count. rst pulse mid-run -> all zero immediately, async.
6. With TIME_CNT_ALARM_EN: alarm 07:30, load 07:29:58 -> alarm_hit pulses once at 07:30:00. Loading 07:30:00 gives no pulse.
